// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment capture path: segment patterns (active-low,
// a is MSB) and the capture FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

endpackage

// File: rtl/seg7_decode.sv
// Inverse seven-segment decode: active-low segment pattern back to a hex nibble,
// flagging the all-off blank pattern separately from illegal patterns.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic       legal,
  output logic       blank,
  output logic [3:0] val
);

  always_comb begin
    legal = 1'b1;
    blank = 1'b0;
    val   = 4'h0;
    case (seg_n)
      SEG_0:     val = 4'h0;
      SEG_1:     val = 4'h1;
      SEG_2:     val = 4'h2;
      SEG_3:     val = 4'h3;
      SEG_4:     val = 4'h4;
      SEG_5:     val = 4'h5;
      SEG_6:     val = 4'h6;
      SEG_7:     val = 4'h7;
      SEG_8:     val = 4'h8;
      SEG_9:     val = 4'h9;
      SEG_A:     val = 4'hA;
      SEG_B:     val = 4'hB;
      SEG_C:     val = 4'hC;
      SEG_D:     val = 4'hD;
      SEG_E:     val = 4'hE;
      SEG_F:     val = 4'hF;
      SEG_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Captures digits from a multiplexed active-low seven-segment bus once each digit has
// been stable for STABLE_CYCLES samples, storing them in a per-digit register file.
//   state   | meaning
//   IDLE    | no single anode active; waiting for one
//   SETTLE  | counting identical samples of the snapshot
//   CAPTURE | decode snapshot, update register file / pulses
//   HOLD    | snapshot already captured; wait for the bus to change
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter  int DIGITS        = 8,
  parameter  int STABLE_CYCLES = 4,
  localparam int IW            = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [6:0]             seg_n,
  input  logic [DIGITS-1:0]      an_n,
  input  logic                   clear,
  output logic [DIGITS-1:0][3:0] digits,
  output logic [DIGITS-1:0]      digit_valid,
  output logic                   upd,
  output logic [IW-1:0]          upd_idx,
  output logic [3:0]             upd_val,
  output logic                   err,
  output logic [IW-1:0]          err_idx
);

  localparam int                SW      = DIGITS + 7;
  localparam logic [7:0]        CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [DIGITS-1:0] ONE_D   = 1;

  logic [SW-1:0]            sync1_q, sync1_d, sync2_q, sync2_d, snap_q, snap_d;
  state_e                   state_q, state_d;
  logic [7:0]               cnt_q, cnt_d, cnt_inc;
  logic [DIGITS-1:0][3:0]   digits_q, digits_d;
  logic [DIGITS-1:0]        valid_q, valid_d;
  logic                     upd_q, upd_d, err_q, err_d;
  logic [IW-1:0]            upd_idx_q, upd_idx_d, err_idx_q, err_idx_d;
  logic [3:0]               upd_val_q, upd_val_d;

  logic [DIGITS-1:0]        s_low;
  logic                     s_single;
  logic [IW-1:0]            snap_idx;
  logic                     dec_legal, dec_blank;
  logic [3:0]               dec_val;

  always_comb begin
    sync1_d = {an_n, seg_n};
    sync2_d = sync1_q;
  end

  // Exactly one anode low: nonzero and a power of two.
  always_comb begin
    s_low    = ~sync2_q[SW-1:7];
    s_single = (s_low != '0) && ((s_low & (s_low - ONE_D)) == '0);
  end

  always_comb begin
    snap_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!snap_q[7+i]) snap_idx = IW'(i);
    end
  end

  seg7_decode u_decode (
    .seg_n (snap_q[6:0]),
    .legal (dec_legal),
    .blank (dec_blank),
    .val   (dec_val)
  );

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q >= CNT_MAX) ? cnt_q : cnt_q + 8'd1;
    case (state_q)
      ST_SETTLE: begin
        if (sync2_q == snap_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CNT_MAX) state_d = ST_CAPTURE;
        end else if (s_single) begin
          snap_d = sync2_q;
          cnt_d  = 8'd1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      end
      ST_CAPTURE: state_d = ST_HOLD;
      ST_IDLE, ST_HOLD: begin
        if (state_q == ST_IDLE || sync2_q != snap_q) begin
          if (s_single) begin
            snap_d  = sync2_q;
            cnt_d   = 8'd1;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // clear overrides a capture landing in the same cycle, pulses included.
  always_comb begin
    digits_d  = digits_q;
    valid_d   = valid_q;
    upd_d     = 1'b0;
    err_d     = 1'b0;
    upd_idx_d = upd_idx_q;
    upd_val_d = upd_val_q;
    err_idx_d = err_idx_q;
    if (clear) begin
      digits_d = '0;
      valid_d  = '0;
    end else if (state_q == ST_CAPTURE) begin
      if (dec_legal) begin
        digits_d[snap_idx] = dec_val;
        valid_d[snap_idx]  = 1'b1;
        upd_d              = 1'b1;
        upd_idx_d          = snap_idx;
        upd_val_d          = dec_val;
      end else begin
        valid_d[snap_idx] = 1'b0;
        if (!dec_blank) begin
          err_d     = 1'b1;
          err_idx_d = snap_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      snap_q    <= '1;
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      digits_q  <= '0;
      valid_q   <= '0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
      upd_idx_q <= '0;
      upd_val_q <= 4'h0;
      err_idx_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      snap_q    <= snap_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
      upd_idx_q <= upd_idx_d;
      upd_val_q <= upd_val_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign upd         = upd_q;
  assign err         = err_q;
  assign upd_idx     = upd_idx_q;
  assign upd_val     = upd_val_q;
  assign err_idx     = err_idx_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench: bus phases are driven from a table/random source, a phase-level
// model predicts captures into a queue, and a negedge monitor pops and compares.
module tb_seg7_scan_capture;

  localparam int DIGITS = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   clear = 1'b0;
  logic [6:0]             seg_n = 7'h7F;
  logic [DIGITS-1:0]      an_n = 8'hFF;
  logic [DIGITS-1:0][3:0] digits;
  logic [DIGITS-1:0]      digit_valid;
  logic                   upd, err;
  logic [2:0]             upd_idx, err_idx;
  logic [3:0]             upd_val;

  seg7_scan_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .clear       (clear),
    .digits      (digits),
    .digit_valid (digit_valid),
    .upd         (upd),
    .upd_idx     (upd_idx),
    .upd_val     (upd_val),
    .err         (err),
    .err_idx     (err_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       is_err;
    logic [2:0] idx;
    logic [3:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_upd_cyc = -1;
  int   phase_start = 0;

  logic [6:0] pat [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic [DIGITS-1:0][3:0] m_digits = '0;
  logic [DIGITS-1:0]      m_valid = '0;
  logic [14:0]            prev_key = '1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [7:0] an);
    int n = 0;
    int k = -1;
    for (int i = 0; i < 8; i++) begin
      if (!an[i]) begin
        n++;
        k = i;
      end
    end
    return (n == 1) ? k : -1;
  endfunction

  function automatic int decode(input logic [6:0] s);
    if (s == 7'h7F) return 16;
    for (int v = 0; v < 16; v++) begin
      if (pat[v] == s) return v;
    end
    return -1;
  endfunction

  // Model: a single-anode phase of >=5 cycles that differs from the previous phase
  // produces exactly one capture; phases of 1..3 cycles never do.
  function automatic void model_capture(input int idx, input int v);
    exp_t e;
    if (v >= 0 && v < 16) begin
      e.is_err = 1'b0; e.idx = idx[2:0]; e.val = v[3:0];
      exp_q.push_back(e);
      m_digits[idx] = v[3:0];
      m_valid[idx]  = 1'b1;
    end else if (v == 16) begin
      m_valid[idx] = 1'b0;
    end else begin
      e.is_err = 1'b1; e.idx = idx[2:0]; e.val = 4'h0;
      exp_q.push_back(e);
      m_valid[idx] = 1'b0;
    end
  endfunction

  task automatic run_phase(input logic [7:0] an, input logic [6:0] seg, input int len);
    int idx;
    idx = idx_of(an);
    if (idx >= 0 && len >= 5 && {an, seg} !== prev_key) model_capture(idx, decode(seg));
    prev_key    = {an, seg};
    an_n        = an;
    seg_n       = seg;
    phase_start = cyc;
    repeat (len) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (upd || err)) begin
      check("upd_err_exclusive", {31'd0, upd && err}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'd0, upd, err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", {31'd0, err}, {31'd0, e.is_err});
        check("event_idx", {29'd0, (err ? err_idx : upd_idx)}, {29'd0, e.idx});
        if (!e.is_err) check("upd_val", {28'd0, upd_val}, {28'd0, e.val});
      end
      if (upd) last_upd_cyc = cyc;
    end
  end

  logic [3:0] scan_vals [8] = '{4'hA, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF};

  initial begin
    int c;
    exp_t e;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digits", digits, 32'd0);
    check("rst_valid", {24'd0, digit_valid}, 32'd0);
    check("rst_upd", {31'd0, upd}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_upd_idx", {29'd0, upd_idx}, 32'd0);
    check("rst_upd_val", {28'd0, upd_val}, 32'd0);
    check("rst_err_idx", {29'd0, err_idx}, 32'd0);
    rst = 1'b0;

    run_phase(8'hFF, 7'h7F, 20);
    check("idle_valid", {24'd0, digit_valid}, 32'd0);

    run_phase(8'b1111_1011, 7'b0010010, 12);
    check("single_latency", last_upd_cyc, phase_start + 7);
    check("single_digit2", {28'd0, digits[2]}, 32'd2);
    check("single_valid", {24'd0, digit_valid}, 32'h04);

    run_phase(8'b1111_0111, 7'b0000110, 3);
    run_phase(8'hFF, 7'h7F, 6);
    check("glitch_valid", {24'd0, digit_valid}, 32'h04);

    run_phase(8'b1111_1100, 7'b0000001, 10);
    check("multi_valid", {24'd0, digit_valid}, 32'h04);

    for (int pass = 0; pass < 2; pass++) begin
      for (int d = 0; d < 8; d++) run_phase(~(8'b1 << d), pat[scan_vals[d]], 8);
    end
    repeat (4) @(posedge clk);
    #1;
    check("scan_digits", digits, 32'hF654321A);
    check("scan_valid", {24'd0, digit_valid}, 32'hFF);
    check("scan_drained", exp_q.size(), 32'd0);

    run_phase(8'b1101_1111, 7'b1111110, 8);
    check("err_idx", {29'd0, err_idx}, 32'd5);
    check("err_valid", {24'd0, digit_valid}, 32'hDF);
    check("err_digit5", {28'd0, digits[5]}, 32'd5);
    run_phase(8'b1101_1111, 7'b1111111, 8);
    check("blank_valid", {24'd0, digit_valid}, 32'hDF);

    for (int p = 0; p < 150; p++) begin
      logic [7:0] an;
      logic [6:0] seg;
      int r, a, b, len;
      do begin
        r = $urandom_range(0, 99);
        if (r < 70) an = ~(8'b1 << $urandom_range(0, 7));
        else if (r < 85) an = 8'hFF;
        else begin
          a  = $urandom_range(0, 7);
          b  = (a + 1 + $urandom_range(0, 6)) % 8;
          an = ~((8'b1 << a) | (8'b1 << b));
        end
        r = $urandom_range(0, 99);
        if (r < 60) seg = pat[$urandom_range(0, 15)];
        else if (r < 75) seg = 7'h7F;
        else seg = 7'($urandom);
      end while ({an, seg} === prev_key);
      len = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : $urandom_range(5, 10);
      run_phase(an, seg, len);
    end
    run_phase(8'hFF, 7'h7F, 6);
    check("rand_digits", digits, m_digits);
    check("rand_valid", {24'd0, digit_valid}, {24'd0, m_valid});

    // clear lands exactly on the CAPTURE cycle
    an_n = 8'b1111_1101;
    seg_n = pat[7];
    prev_key = {an_n, seg_n};
    c = cyc;
    repeat (6) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    m_digits = '0;
    m_valid  = '0;
    repeat (4) @(posedge clk);
    #1;
    check("clear_valid", {24'd0, digit_valid}, 32'd0);
    check("clear_digits", digits, 32'd0);
    check("clear_no_upd", {31'd0, last_upd_cyc == c + 7}, 32'd0);

    run_phase(8'hFF, 7'h7F, 6);
    an_n = 8'b1110_1111;
    seg_n = pat[9];
    prev_key = {an_n, seg_n};
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_digits", digits, 32'd0);
    check("rst_mid_valid", {24'd0, digit_valid}, 32'd0);
    check("rst_mid_upd", {31'd0, upd}, 32'd0);
    check("rst_mid_err", {31'd0, err}, 32'd0);
    m_digits = '0;
    m_valid  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    c = cyc;
    e.is_err = 1'b0; e.idx = 3'd4; e.val = 4'h9;
    exp_q.push_back(e);
    m_digits[4] = 4'h9;
    m_valid[4]  = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rst_release_latency", last_upd_cyc, c + 7);

    run_phase(8'hFF, 7'h7F, 6);
    check("final_drained", exp_q.size(), 32'd0);
    check("final_digits", digits, m_digits);
    check("final_valid", {24'd0, digit_valid}, {24'd0, m_valid});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive side of the multiplexed 8-digit seven-segment bus: samples active-low anode and segment lines as driven by the display scanner.
- Waits for each digit to be stable, decodes the segment pattern back to a 4-bit hex value, and stores it in a per-digit register file with valid flags.
- Used for loopback self-check and board-level verification of the display path; sits beside the display driver on the same clk.

Parameters:
- DIGITS, 8, number of anode lines (index width IW = $clog2(DIGITS)).
- STABLE_CYCLES, 4, consecutive identical samples required before capture; legal range 2..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- seg_n  in  7  segments {a,b,c,d,e,f,g}, active-low, a is MSB; asynchronous to clk.
- an_n  in  DIGITS  anodes, active-low, bit i selects digit i; asynchronous to clk.
- clear  in  1  synchronous clear of digits/digit_valid.
- digits  out  DIGITS x 4  captured value per digit.
- digit_valid  out  DIGITS  digit i holds a legal captured value.
- upd  out  1  one-cycle pulse: legal digit captured.
- upd_idx  out  IW  digit index of the last capture.
- upd_val  out  4  value of the last capture.
- err  out  1  one-cycle pulse: illegal segment pattern captured.
- err_idx  out  IW  digit index of the last error.

Behaviour:
- Reset: digits=0, digit_valid=0, upd=0, upd_idx=0, upd_val=0, err=0, err_idx=0, FSM=IDLE, counter=0. Synchronizer flops reset to all-ones (inactive).
- Input path: 2-flop synchronizer on {an_n, seg_n}. Sample S = second-stage value.
- A sample is "single" when exactly one an_n bit is 0.
- FSM states are IDLE, SETTLE, CAPTURE, HOLD.
- IDLE: if S is single, snapshot S, set cnt=1, go to SETTLE. Otherwise stay in IDLE; this covers all anodes high (blank during write) and multiple anodes low.
- SETTLE with S==snapshot: cnt++. When cnt reaches STABLE_CYCLES, go to CAPTURE.
- SETTLE with S!=snapshot: if S is single, re-snapshot, set cnt=1, stay in SETTLE. Otherwise go to IDLE.
- CAPTURE (one cycle): decode the snapshot segments. Outputs register at the end of the cycle, then the FSM goes to HOLD.
- Legal pattern: digits[idx]=val, digit_valid[idx]=1, upd=1, upd_idx=idx, upd_val=val.
- Blank pattern 1111111: digit_valid[idx]=0, digits[idx] unchanged, no upd, no err.
- Any other pattern: digit_valid[idx]=0, digits[idx] unchanged, err=1, err_idx=idx.
- HOLD: wait for S!=snapshot, then apply the IDLE entry rule in the same cycle. A static digit is captured exactly once per appearance.
- Latency: pins settle before edge 1 → upd/err high in the cycle after edge STABLE_CYCLES+3. With the default, that is high after edge 7 for exactly one cycle.
- upd and err are never high in the same cycle. Both deassert automatically after one cycle.
- Decode table, seg_n→val: 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9, 0001000→A, 1100000→B, 0110001→C, 1000010→D, 0110000→E, 0111000→F.
- clear: zeroes digits and digit_valid. The FSM is not disturbed.
- clear in the same cycle as CAPTURE: clear wins, and upd/err are suppressed.
- cnt saturates at STABLE_CYCLES and never wraps.
- Asynchronous rst mid-SETTLE/CAPTURE returns everything to reset values immediately. The first capture after release obeys full latency.

Decomposition:
- Package seg7_pkg holds the 16 segment pattern constants, SEG_BLANK=7'b1111111, and the state enum typedef (IDLE, SETTLE, CAPTURE, HOLD).
- One combinational sub-module, seg7_decode: seg_n[6:0] → {legal, blank, val[3:0]}.
- Onehot detect and index encode stay inline.

Test Plan:
- Reset: assert rst mid-run → digits=0, digit_valid=0, upd=0, err=0 immediately. All ones on inputs after release → no activity.
- Single digit: an_n=1111_1011, seg_n=0010010 held 12 cycles → exactly one upd, high after edge 7, upd_idx=2, upd_val=2, digits[2]=2, digit_valid=0000_0100.
- Glitch reject: digit 3 with seg_n=0000110 held 3 cycles, then an_n=FF → no upd, digit_valid unchanged.
- Full scan: digits 0..7 driven sequentially with values A,1,2,3,4,5,6,F, 8 cycles each, repeated twice → 16 upd pulses in index order, digits match, digit_valid=FF.
- Errors/blank: digit 5 with seg_n=1111110 → err pulse, err_idx=5, digit_valid[5]=0, digits[5] unchanged. Then seg_n=1111111 → no err, no upd.
- Corner cases:
  - an_n=1111_1100 for 10 cycles → no capture.
  - clear asserted in the CAPTURE cycle → digit_valid=0, no upd.
  - rst pulsed mid-SETTLE → no upd; a new capture follows full latency.
